// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_pkg
// Description : Shared constants and types for the AES streaming wrapper.
//               AES_BLK_W    - AES block width in bits
//               AES_CORE_LAT - pipeline latency of the aes_128 core
//               AES_TAG_W    - default width of the user tag
//               aes_entry_t  - output FIFO entry {tag, data}
// Revision    : 1.0 - initial release
// ============================================================================
package aes_stream_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int AES_CORE_LAT = 20;
  localparam int AES_TAG_W    = 4;

  typedef struct packed {
    logic [AES_TAG_W-1:0] tag;
    logic [AES_BLK_W-1:0] data;
  } aes_entry_t;

endpackage
`default_nettype wire

// File: rtl/aes_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_out_fifo
// Description : Synchronous show-ahead FIFO. The head entry is visible on
//               head_o whenever empty_o is low; pop_i advances to the next.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous reset, active low
//               push_i      - write push_data_i at the end of this cycle
//               push_data_i - entry to write
//               pop_i       - discard the head entry at the end of this cycle
//               head_o      - current head entry (show-ahead)
//               full_o      - DEPTH entries stored
//               empty_o     - no entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module aes_out_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; entries are only ever read between the pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_ctrl
// Description : Valid/ready streaming wrapper around the non-stallable,
//               fully pipelined aes_128 core. Tracks which core slots hold
//               real blocks, captures finished ciphertext into an output
//               FIFO and admits new blocks only while FIFO space is credited.
// Ports       : clk, rst        - clock; synchronous active-low reset
//               in_valid/ready  - input handshake
//               in_state/key/tag- plaintext, key and user tag
//               core_state/key  - pass-through drive of the core inputs
//               core_out        - core ciphertext output
//               out_valid/ready - output handshake
//               out_data/tag    - ciphertext and its tag
//               busy            - any block in flight or buffered
// Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int LAT   = AES_CORE_LAT,
  parameter int DEPTH = 32,
  parameter int TAG_W = AES_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_state,
  input  logic [AES_BLK_W-1:0] in_key,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [AES_BLK_W-1:0] core_state,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam int               ENTRY_W = TAG_W + AES_BLK_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic               in_fire;
  logic               out_fire;
  logic [LAT-1:0]     vld_sr_q;
  logic [TAG_W-1:0]   tag_sr_q [LAT];
  logic [CNT_W-1:0]   used_q, used_d;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  // The core samples every edge; bubbles are simply marked invalid.
  assign core_state = in_state;
  assign core_key   = in_key;

  // Admission is gated only by the registered credit count, so a pop
  // re-opens in_ready on the following cycle rather than combinationally.
  assign in_ready  = rst & (used_q < DEPTH_C);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign out_fire  = out_valid & out_ready;
  assign {out_tag, out_data} = fifo_head;
  assign busy      = (used_q != '0);

  // Slot i of the shift register mirrors core pipeline stage i; the top bit
  // is set exactly in the cycle core_out holds that block's ciphertext.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= in_fire;
      for (int i = 1; i < LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

  // Tags need no reset: they are only consumed when qualified by vld_sr_q.
  always_ff @(posedge clk) begin
    tag_sr_q[0] <= in_tag;
    for (int i = 1; i < LAT; i++) begin
      tag_sr_q[i] <= tag_sr_q[i-1];
    end
  end

  // Credits cover in-flight plus buffered blocks, so FIFO space is reserved
  // at admission time and a push can never find the FIFO full.
  always_comb begin
    used_d = used_q;
    case ({in_fire, out_fire})
      2'b10:   used_d = used_q + CNT_W'(1);
      2'b01:   used_d = used_q - CNT_W'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

  // The full qualifier is defensive; the credit invariant keeps it inert.
  assign fifo_push = vld_sr_q[LAT-1] & ~fifo_full;

  aes_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({tag_sr_q[LAT-1], core_out}),
    .pop_i       (out_fire),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_stream_ctrl
// Description : Self-checking bench for aes_stream_ctrl with a behavioural
//               AES-128 core model and an input-order reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_stream_ctrl;
  import aes_stream_pkg::*;

  localparam int LAT   = 20;
  localparam int DEPTH = 32;
  localparam int TAG_W = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [127:0]     in_state, in_key;
  logic [TAG_W-1:0] in_tag;
  logic [127:0]     core_state, core_key, core_out;
  logic             out_valid, out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  aes_stream_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_tag(in_tag),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc, t0, t1, t2, t3, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t0 = sbox[k[13]] ^ rc; t1 = sbox[k[14]]; t2 = sbox[k[15]]; t3 = sbox[k[12]];
      k[0] ^= t0; k[1] ^= t1; k[2] ^= t2; k[3] ^= t3;
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: never reset, samples its inputs on every edge.
  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= aes128(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  // ---------------- reference queues ----------------
  typedef struct {
    aes_entry_t e;
    int         cyc;
  } rec_t;
  rec_t exp_q[$];
  rec_t got_q[$];
  rec_t mon_in, mon_out;

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      mon_in.e.tag  = in_tag;
      mon_in.e.data = aes128(in_state, in_key);
      mon_in.cyc    = cyc;
      exp_q.push_back(mon_in);
    end
    if (out_valid && out_ready) begin
      mon_out.e.tag  = out_tag;
      mon_out.e.data = out_data;
      mon_out.cyc    = cyc;
      got_q.push_back(mon_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_payload();
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_tag   = TAG_W'($urandom);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_outs(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) step();
  endtask

  // Fill with out_ready low until admission stops, holding payload until fire.
  task automatic fill_fifo();
    logic f;
    out_ready = 1'b0;
    rand_payload();
    in_valid = 1'b1;
    for (int k = 0; k < DEPTH + LAT + 8; k++) begin
      f = in_ready;
      step();
      if (f) rand_payload();
    end
  endtask

  task automatic run_fips(output int lat, output logic [127:0] d, output logic [TAG_W-1:0] tg);
    int t0;
    lat = -1; d = '0; tg = '0;
    out_ready = 1'b1;
    in_state = FIPS_PT; in_key = FIPS_KEY; in_tag = TAG_W'(5);
    in_valid = 1'b1;
    t0 = cyc;
    step();
    in_valid = 1'b0;
    rand_payload();
    for (int k = 0; k < 3 * LAT; k++) begin
      if (out_valid) begin
        lat = cyc - t0; d = out_data; tg = out_tag;
        break;
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rand_payload();
    repeat (3) step();
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fips();
    int lat; logic [127:0] d; logic [TAG_W-1:0] tg;
    clear_q();
    run_fips(lat, d, tg);
    checks++; if (lat !== LAT + 1) begin errs++; $display("FAIL fips_latency: got %0d expected %0d", lat, LAT + 1); end
    checks++; if (d !== FIPS_CT) begin errs++; $display("FAIL fips_data: got %h expected %h", d, FIPS_CT); end
    checks++; if (tg !== TAG_W'(5)) begin errs++; $display("FAIL fips_tag: got %0d expected 5", tg); end
    step();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL fips_idle: got busy=%b out_valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    int drops = 0, bad = 0, gaps = 0;
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1; rand_payload();
      if (!in_ready) drops++;
      step();
    end
    in_valid = 1'b0;
    wait_outs(64, LAT + 80);
    checks++; if (drops != 0) begin errs++; $display("FAIL b2b_in_ready: got %0d drops expected 0", drops); end
    checks++; if (got_q.size() != 64 || exp_q.size() != 64) begin
      errs++; $display("FAIL b2b_count: got %0d outs %0d ins expected 64 64", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        if (got_q[i].e !== exp_q[i].e) bad++;
        if (got_q[i].cyc != got_q[0].cyc + i) gaps++;
      end
      checks++; if (bad != 0) begin errs++; $display("FAIL b2b_data: got %0d wrong entries expected 0", bad); end
      checks++; if (gaps != 0) begin errs++; $display("FAIL b2b_contiguous: got %0d gaps expected 0", gaps); end
      checks++; if (got_q[0].cyc - exp_q[0].cyc != LAT + 1) begin
        errs++; $display("FAIL b2b_latency: got %0d expected %0d", got_q[0].cyc - exp_q[0].cyc, LAT + 1); end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_q();
    fill_fifo();
    checks++; if (exp_q.size() != DEPTH) begin errs++; $display("FAIL bp_accepts: got %0d expected %0d", exp_q.size(), DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL bp_full_state: got out_valid=%b busy=%b expected 1 1", out_valid, busy); end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_no_comb_reopen: got %b expected 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
    wait_outs(DEPTH, DEPTH + 20);
    repeat (5) step();
    checks++; if (got_q.size() != DEPTH) begin errs++; $display("FAIL bp_drain_count: got %0d expected %0d", got_q.size(), DEPTH); end
    else begin
      for (int i = 0; i < DEPTH; i++) if (got_q[i].e !== exp_q[i].e) bad++;
      checks++; if (bad != 0) begin errs++; $display("FAIL bp_drain_order: got %0d wrong entries expected 0", bad); end
    end
  endtask

  task automatic test_bubbles();
    int bad = 0;
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rand_payload();
      in_valid = (k % 2 == 0);
      in_tag = TAG_W'(k / 2);
      step();
    end
    in_valid = 1'b0;
    repeat (LAT + 10) step();
    checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin
      errs++; $display("FAIL bubble_count: got %0d outs expected 8", got_q.size()); end
    else begin
      for (int i = 0; i < 8; i++)
        if (got_q[i].e.tag !== TAG_W'(i) || got_q[i].e.data !== exp_q[i].e.data) bad++;
      checks++; if (bad != 0) begin errs++; $display("FAIL bubble_order: got %0d wrong entries expected 0", bad); end
    end
  endtask

  task automatic test_full_simul();
    int bad = 0, wrong = 0;
    clear_q();
    fill_fifo();
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fs_first_cycle_ready: got %b expected 0", in_ready); end
    step();
    for (int k = 0; k < 40; k++) begin
      if (!(in_ready && out_valid)) bad++;
      step();
      rand_payload();
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errs++; $display("FAIL fs_steady: got %0d stalled cycles expected 0", bad); end
    checks++; if (exp_q.size() != DEPTH + 40) begin
      errs++; $display("FAIL fs_accepts: got %0d expected %0d", exp_q.size(), DEPTH + 40); end
    wait_outs(exp_q.size(), DEPTH + LAT + 60);
    checks++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL fs_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else begin
      foreach (got_q[i]) if (got_q[i].e !== exp_q[i].e) wrong++;
      checks++; if (wrong != 0) begin errs++; $display("FAIL fs_order: got %0d wrong entries expected 0", wrong); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lat; logic [127:0] d; logic [TAG_W-1:0] tg;
    clear_q();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin in_valid = 1'b1; rand_payload(); step(); end
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    for (int k = 0; k < 10; k++) begin in_valid = 1'b1; rand_payload(); step(); end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || exp_q.size() != 13) begin
      errs++; $display("FAIL rm_setup: got out_valid=%b accepts=%0d expected 1 13", out_valid, exp_q.size()); end
    rst = 1'b0;
    step();
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rm_after_reset: got out_valid=%b busy=%b expected 0 0", out_valid, busy); end
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen != 0 || got_q.size() != 0) begin
      errs++; $display("FAIL rm_stale: got %0d stale outputs expected 0", seen); end
    run_fips(lat, d, tg);
    checks++; if (lat !== LAT + 1 || d !== FIPS_CT || tg !== TAG_W'(5)) begin
      errs++; $display("FAIL rm_fresh: got lat=%0d data=%h tag=%0d expected %0d %h 5", lat, d, tg, LAT + 1, FIPS_CT); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_full_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
